// File: rtl/calc_pkg.sv
// Shared keycodes, operator and state enums for the param_calc calculator.
package calc_pkg;

    localparam logic [4:0] KEY_SQR     = 5'h01;
    localparam logic [4:0] KEY_CH_SIGN = 5'h02;
    localparam logic [4:0] KEY_EQUALS  = 5'h03;
    localparam logic [4:0] KEY_CA      = 5'h04;
    localparam logic [4:0] KEY_MS      = 5'h05;
    localparam logic [4:0] KEY_MR      = 5'h06;
    localparam logic [4:0] KEY_MC      = 5'h07;
    localparam logic [4:0] KEY_MULTI   = 5'h09;
    localparam logic [4:0] KEY_MINUS   = 5'h0A;
    localparam logic [4:0] KEY_PLUS    = 5'h0B;
    localparam logic [4:0] KEY_CE      = 5'h0C;

    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_e;
    typedef enum logic       {ENTRY_NEW, ENTRY_APPEND}         entry_e;
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE}           mstate_e;

    function automatic op_e key2op(input logic [4:0] k);
        case (k)
            KEY_PLUS:  return OP_ADD;
            KEY_MINUS: return OP_SUB;
            KEY_MULTI: return OP_MUL;
            default:   return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/calc_mult.sv
// Iterative signed shift-add multiplier: one multiplier bit per RUN cycle,
// the last (sign) bit carries negative weight.
module calc_mult
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mstate_e             state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]    mplier;

    always_ff @(posedge clk) begin
        if (rst) state <= M_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            M_IDLE: if (start)       state_nx = M_RUN;
            M_RUN:  if (cnt == LAST) state_nx = M_DONE;
            M_DONE:                  state_nx = M_IDLE;
            default:                 state_nx = M_IDLE;
        endcase
        if (abort) state_nx = M_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == M_IDLE && start && !abort) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier <= b;
        end else if (state == M_RUN) begin
            // two's-complement weight of the multiplier's sign bit is negative
            if (mplier[0]) acc <= (cnt == LAST) ? acc - mcand : acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign busy    = (state != M_IDLE);
    assign done    = (state == M_DONE);
    assign product = acc[WIDTH-1:0];
    assign ovf     = !((&acc[2*WIDTH-1:WIDTH-1]) || !(|acc[2*WIDTH-1:WIDTH-1]));

endmodule

// File: rtl/param_calc.sv
// Hex pocket-calculator core with chained operators and iterative multiply.
// Optional memory keys MS/MR/MC are built when CALC_MEMORY_EN is defined.
module param_calc
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       keycode,
    input  logic             newkey,
    output logic [WIDTH-1:0] Xdisplay,
    output logic             LED_NEG_digit,
    output logic             LED_OVW,
    output logic             busy
);
    logic [WIDTH-1:0] x, y;
    op_e              pend;
    entry_e           entry;
    logic             ovw, newkey_q, mul_to_y;
`ifdef CALC_MEMORY_EN
    logic [WIDTH-1:0] mem;
`endif

    logic             key_ev, take, is_ca, resolve;
    logic [WIDTH-1:0] ar_sum, ar_dif, ar_res;
    logic             ar_ovf;
    logic             mul_start, mul_busy, mul_done, mul_ovf;
    logic [WIDTH-1:0] mul_a, mul_prod;

    always_comb begin
        key_ev    = newkey & ~newkey_q;
        is_ca     = key_ev && (keycode == KEY_CA);
        take      = key_ev && !mul_busy;
        resolve   = (pend != OP_NONE) && (entry == ENTRY_APPEND);
        ar_sum    = y + x;
        ar_dif    = y - x;
        ar_res    = ar_sum;
        ar_ovf    = (y[WIDTH-1] == x[WIDTH-1]) && (ar_sum[WIDTH-1] != y[WIDTH-1]);
        if (pend == OP_SUB) begin
            ar_res = ar_dif;
            ar_ovf = (y[WIDTH-1] != x[WIDTH-1]) && (ar_dif[WIDTH-1] != y[WIDTH-1]);
        end
        mul_start = 1'b0;
        mul_a     = y;
        if (take) begin
            case (keycode)
                KEY_PLUS, KEY_MINUS, KEY_MULTI: mul_start = resolve && (pend == OP_MUL);
                KEY_EQUALS: mul_start = (pend == OP_MUL);
                KEY_SQR: begin
                    mul_start = 1'b1;
                    mul_a     = x;
                end
                default: ;
            endcase
        end
    end

    calc_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (is_ca),
        .a       (mul_a),
        .b       (x),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod),
        .ovf     (mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            pend     <= OP_NONE;
            entry    <= ENTRY_NEW;
            ovw      <= 1'b0;
            newkey_q <= 1'b0;
            mul_to_y <= 1'b0;
`ifdef CALC_MEMORY_EN
            mem      <= '0;
`endif
        end else begin
            newkey_q <= newkey;
            if (mul_done) begin
                x   <= mul_prod;
                ovw <= mul_ovf;
                if (mul_to_y) y <= mul_prod;
            end
            // CA is honoured even mid-multiply; everything else waits for idle
            if (is_ca) begin
                x     <= '0;
                y     <= '0;
                pend  <= OP_NONE;
                ovw   <= 1'b0;
                entry <= ENTRY_NEW;
            end else if (take) begin
                case (keycode)
                    KEY_PLUS, KEY_MINUS, KEY_MULTI: begin
                        if (!resolve) begin
                            y <= x;
                        end else if (pend == OP_MUL) begin
                            mul_to_y <= 1'b1;
                        end else begin
                            x   <= ar_res;
                            y   <= ar_res;
                            ovw <= ar_ovf;
                        end
                        pend  <= key2op(keycode);
                        entry <= ENTRY_NEW;
                    end
                    KEY_EQUALS: begin
                        if (pend != OP_NONE) begin
                            if (pend == OP_MUL) begin
                                mul_to_y <= 1'b0;
                            end else begin
                                x   <= ar_res;
                                ovw <= ar_ovf;
                            end
                            pend  <= OP_NONE;
                            entry <= ENTRY_NEW;
                        end
                    end
                    KEY_SQR: begin
                        mul_to_y <= 1'b0;
                        entry    <= ENTRY_NEW;
                    end
                    KEY_CH_SIGN: begin
                        x     <= '0 - x;
                        entry <= ENTRY_NEW;
                    end
                    KEY_CE: begin
                        x     <= '0;
                        ovw   <= 1'b0;
                        entry <= ENTRY_NEW;
                    end
`ifdef CALC_MEMORY_EN
                    KEY_MS: begin
                        mem   <= x;
                        entry <= ENTRY_NEW;
                    end
                    KEY_MR: begin
                        x     <= mem;
                        entry <= ENTRY_NEW;
                    end
                    KEY_MC: mem <= '0;
`endif
                    default: begin
                        if (keycode[4]) begin
                            if (entry == ENTRY_NEW) begin
                                x     <= {{(WIDTH-4){1'b0}}, keycode[3:0]};
                                entry <= ENTRY_APPEND;
                                ovw   <= 1'b0;
                            end else begin
                                x <= {x[WIDTH-5:0], keycode[3:0]};
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign Xdisplay      = x;
    assign LED_NEG_digit = x[WIDTH-1];
    assign LED_OVW       = ovw;
    assign busy          = mul_busy;

endmodule

// File: tb/tb_param_calc.sv
// Directed bench: a 16-bit and an 8-bit calculator share one key bus.
module tb_param_calc;
    localparam logic [4:0] SQR = 5'h01, CHS = 5'h02, EQ = 5'h03, CA = 5'h04;
    localparam logic [4:0] MS = 5'h05, MR = 5'h06, MC = 5'h07;
    localparam logic [4:0] MUL = 5'h09, SUB = 5'h0A, ADD = 5'h0B, CE = 5'h0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  keycode = 5'h00;
    logic        newkey = 1'b0;
    logic [15:0] x16;
    logic [7:0]  x8;
    logic        neg16, ovw16, busy16, neg8, ovw8, busy8;
    int          total = 0, passed = 0, errs = 0, n;

    always #5 clk = ~clk;

    param_calc #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .keycode(keycode), .newkey(newkey),
        .Xdisplay(x16), .LED_NEG_digit(neg16), .LED_OVW(ovw16), .busy(busy16)
    );
    param_calc #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .keycode(keycode), .newkey(newkey),
        .Xdisplay(x8), .LED_NEG_digit(neg8), .LED_OVW(ovw8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errs++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        keycode = k;
        newkey  = 1'b1;
        @(negedge clk);
        newkey  = 1'b0;
    endtask

    task automatic digits(input logic [31:0] v, input int cnt);
        for (int i = cnt - 1; i >= 0; i--) press({1'b1, v[i*4 +: 4]});
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mult_timeout", {31'b0, busy16}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_x16", x16, 16'h0000);
        chk("rst_ovw16", ovw16, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_x8", x8, 8'h00);
        chk("rst_busy8", busy8, 0);

        digits(32'h1234, 4);          chk("entry_1234", x16, 16'h1234);
        press(CE);                    chk("ce", x16, 16'h0000);
        digits(32'h12, 2); press(CHS); chk("chs_neg", x16, 16'hFFEE);
        chk("neg_led", neg16, 1);
        press(CHS);                   chk("chs_pos", x16, 16'h0012);

        press(CA);
        digits(32'h12, 2); press(ADD); press(5'h15); press(EQ);
        chk("add_17", x16, 16'h0017);
        press(ADD); digits(32'h1111, 4); press(EQ);
        chk("add_1128", x16, 16'h1128);
        chk("add_ovw0", ovw16, 0);
        press(5'h15); press(SUB); press(5'h16); press(EQ);
        chk("sub_ffff", x16, 16'hFFFF);
        chk("sub_neg", neg16, 1);

        press(CA);
        digits(32'h512, 3); press(MUL); digits(32'h23, 2); press(EQ);
        wait_idle(n);
        chk("mul_busy_cycles", n, 17);
        chk("mul_b176", x16, 16'hB176);
        chk("mul_ovw1", ovw16, 1);
        digits(32'hFFFF, 4); press(MUL); digits(32'hFFFF, 4); press(EQ);
        wait_idle(n);
        chk("mul_neg1sq", x16, 16'h0001);
        chk("mul_ovw0", ovw16, 0);

        press(CA);
        digits(32'h12, 2); press(CHS); press(SQR);
        press(5'h17);
        wait_idle(n);
        chk("sqr_144", x16, 16'h0144);
        press(SQR);
        repeat (3) @(negedge clk);
        press(CA);
        chk("ca_abort_x", x16, 16'h0000);
        chk("ca_abort_busy", busy16, 0);
        repeat (20) @(negedge clk);
        chk("ca_abort_stays", x16, 16'h0000);

        press(5'h12); press(ADD); press(5'h13); press(MUL); press(5'h14); press(EQ);
        wait_idle(n);
        chk("chain_add_mul", x16, 16'h0014);
        press(CA);
        press(5'h12); press(MUL); press(5'h13); press(ADD);
        wait_idle(n);
        chk("chain_mul_x", x16, 16'h0006);
        press(5'h11); press(EQ);
        chk("chain_mul_y", x16, 16'h0007);
        press(5'h08);
        chk("unassigned", x16, 16'h0007);

        press(CA);
        @(negedge clk);
        keycode = 5'h11;
        newkey  = 1'b1;
        repeat (4) @(negedge clk);
        newkey  = 1'b0;
        chk("held_key", x16, 16'h0001);

        press(CA);
        digits(32'h42, 2); press(MS); press(CA); press(MR);
`ifdef CALC_MEMORY_EN
        chk("mem_recall", x16, 16'h0042);
        press(MC); press(MR);
        chk("mem_clear", x16, 16'h0000);
`else
        press(5'h11);
        chk("mem_absent", x16, 16'h0001);
`endif

        press(CA);
        press(5'h13); press(MUL); press(5'h13); press(EQ);
        @(negedge clk);
        rst     = 1'b1;
        keycode = 5'h19;
        newkey  = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy16, 0);
        chk("rst_mid_x", x16, 16'h0000);
        rst    = 1'b0;
        newkey = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_quiet", x16, 16'h0000);
        press(5'h15);
        chk("post_rst_digit", x16, 16'h0005);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        digits(32'h7F, 2); press(ADD); press(5'h11); press(EQ);
        chk("w8_add_80", x8, 8'h80);
        chk("w8_ovw", ovw8, 1);
        chk("w8_neg", neg8, 1);
        digits(32'h123, 3);
        chk("w8_drop_nibble", x8, 8'h23);
        chk("w8_ovw_clr", ovw8, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("w8_rst_entry", x8, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
